// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and queue-entry type for the fetch queue stage
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;
  localparam logic [3:0] SRAM_WSTRB_NONE = 4'h0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_sync_fifo.sv
// fetch_sync_fifo: synchronous FIFO with flush and occupancy count
// Ports: clk, resetn (sync, active-low), flush (empties), push/din, pop/dout (head), count
module fetch_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop & ~flush & (count_q != '0);
  assign do_push = push & ~flush & ((count_q != CW'(DEPTH)) | do_pop);
  assign dout = mem[rd_q];
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: credit-based instruction fetch with in-order response queue and redirect discard
// Ports: clk/resetn (sync, active-low); fs_* head of instruction queue to decode (ds_allowin pops);
// br_*/wb_ex/ertn_* redirects; inst_sram_* request/response channel.
// Optional FETCH_ADEF_CHECK_EN: misaligned fetch PC raises an address-fault entry instead of a request.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int          OUTSTANDING = 2,
  parameter int          QDEPTH      = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_inst,
  output logic [31:0] fs_pc,
  output logic        fs_adef_ex,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int EW = $bits(fetch_entry_t);
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int TCW = $clog2(OUTSTANDING + 1);
  logic [31:0] pf_pc_q, pf_pc_d, redirect_pc, tag_pc;
  logic [2:0] inflight_q, inflight_d, discard_q, discard_d;
  logic redirect, credit, hs, resp, accept, push, pop, misaligned, adef_push;
  logic [QCW-1:0] occ;
  logic [TCW-1:0] tag_cnt;
  logic [EW-1:0] head_bits;
  fetch_entry_t head, in_entry;
  assign redirect = wb_ex | ertn_flush | br_taken;
  assign redirect_pc = wb_ex ? ex_entry : ertn_flush ? ertn_entry : br_target;
  // inflight counts discarded requests too, so the credit never lets a late response overflow the queue
  assign credit = (int'(inflight_q) < OUTSTANDING) && (int'(inflight_q) + int'(occ) < QDEPTH);
`ifdef FETCH_ADEF_CHECK_EN
  logic adef_done_q;
  assign misaligned = pf_pc_q[1:0] != 2'b00;
  // waiting for inflight==0 keeps the fault entry behind every older response
  assign adef_push = misaligned & ~adef_done_q & ~redirect & (inflight_q == '0) & (int'(occ) < QDEPTH);
  always_ff @(posedge clk) begin
    if (!resetn || redirect) adef_done_q <= 1'b0;
    else if (adef_push) adef_done_q <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
  assign adef_push = 1'b0;
`endif
  assign inst_sram_req = resetn & ~redirect & ~br_stall & credit & ~misaligned;
  assign hs = inst_sram_req & inst_sram_addr_ok;
  // data_ok with nothing outstanding is stale (e.g. across a reset) and is ignored
  assign resp = inst_sram_data_ok & (inflight_q != '0);
  assign accept = resp & ~redirect & (discard_q == '0) & (tag_cnt != '0);
  assign push = accept | adef_push;
  assign pop = fs_to_ds_valid & ds_allowin;
  assign in_entry = adef_push ? fetch_entry_t'{pc: pf_pc_q, inst: 32'h0, adef: 1'b1}
                              : fetch_entry_t'{pc: tag_pc, inst: inst_sram_rdata, adef: 1'b0};
  assign pf_pc_d = redirect ? redirect_pc : hs ? pf_pc_q + 32'd4 : pf_pc_q;
  assign inflight_d = inflight_q + 3'(hs) - 3'(resp);
  assign discard_d = redirect ? inflight_q - 3'(resp) : (resp && discard_q != '0) ? discard_q - 3'd1 : discard_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pf_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q <= '0;
    end else begin
      pf_pc_q <= pf_pc_d;
      inflight_q <= inflight_d;
      discard_q <= discard_d;
    end
  end
  fetch_sync_fifo #(.DEPTH(OUTSTANDING), .WIDTH(32)) u_tag_fifo (
    .clk(clk), .resetn(resetn), .flush(redirect), .push(hs), .pop(accept),
    .din(pf_pc_q), .dout(tag_pc), .count(tag_cnt)
  );
  fetch_sync_fifo #(.DEPTH(QDEPTH), .WIDTH(EW)) u_inst_queue (
    .clk(clk), .resetn(resetn), .flush(redirect), .push(push), .pop(pop),
    .din(in_entry), .dout(head_bits), .count(occ)
  );
  assign head = fetch_entry_t'(head_bits);
  assign fs_to_ds_valid = occ != '0;
  assign fs_inst = fs_to_ds_valid ? head.inst : 32'h0;
  assign fs_pc = fs_to_ds_valid ? head.pc : 32'h0;
  assign fs_adef_ex = fs_to_ds_valid & head.adef;
  assign inst_sram_wr = 1'b0;
  assign inst_sram_wstrb = SRAM_WSTRB_NONE;
  assign inst_sram_size = SRAM_SIZE_WORD;
  assign inst_sram_addr = pf_pc_q;
  assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: scoreboard bench for fetch_queue_stage with a behavioural inst_sram slave
module tb_fetch_queue_stage;
  localparam logic [31:0] RPC = 32'h1c000000;
  localparam int OUTS = 2;
  localparam int QD = 4;
`ifdef FETCH_ADEF_CHECK_EN
  localparam bit ADEF = 1'b1;
`else
  localparam bit ADEF = 1'b0;
`endif
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;
  logic clk = 0, resetn = 0, ds_allowin = 0, br_stall = 0, br_taken = 0, wb_ex = 0, ertn_flush = 0;
  logic [31:0] br_target = 0, ex_entry = 0, ertn_entry = 0, inst_sram_rdata = 0;
  logic inst_sram_addr_ok = 0, inst_sram_data_ok = 0;
  logic fs_to_ds_valid, fs_adef_ex, inst_sram_req, inst_sram_wr;
  logic [31:0] fs_inst, fs_pc, inst_sram_addr, inst_sram_wdata;
  logic [3:0] inst_sram_wstrb;
  logic [1:0] inst_sram_size;
  fetch_queue_stage #(.OUTSTANDING(OUTS), .QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_inst(fs_inst), .fs_pc(fs_pc), .fs_adef_ex(fs_adef_ex), .br_stall(br_stall),
    .br_taken(br_taken), .br_target(br_target), .wb_ex(wb_ex), .ex_entry(ex_entry),
    .ertn_flush(ertn_flush), .ertn_entry(ertn_entry), .inst_sram_req(inst_sram_req),
    .inst_sram_wr(inst_sram_wr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, hs = 0, pops = 0;
  bit aok_en = 1, resp_en = 1, force_dok = 0, seen_valid = 0, last_dok = 0, adef_done = 0;
  logic [31:0] model_pc = RPC, inst0;
  pend_t pend[$];
  ent_t exp_q[$];
  logic [31:0] req_log[$];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a0f0f;
  endfunction
  task automatic cyc();
    int occ, inf;
    bit redir, mis, e_req;
    pend_t p;
    ent_t e;
    @(negedge clk);
    inst_sram_addr_ok = aok_en;
    inst_sram_data_ok = force_dok || (resp_en && pend.size() > 0);
    inst_sram_rdata = (pend.size() > 0) ? rd_of(pend[0].addr) : 32'hbad0bad0;
    #1;
    occ = exp_q.size();
    inf = pend.size();
    redir = wb_ex || ertn_flush || br_taken;
    chk("size", 32'(inst_sram_size), 32'h2);
    chk("wr_wstrb_wdata", {27'h0, inst_sram_wr, inst_sram_wstrb} | inst_sram_wdata, 32'h0);
    if (!resetn) begin
      chk("rst_req", 32'(inst_sram_req), 0);
      pend.delete();
      exp_q.delete();
      req_log.delete();
      model_pc = RPC;
      adef_done = 0;
      seen_valid = 0;
      last_dok = 0;
    end else begin
      mis = ADEF && model_pc[1:0] != 2'b00;
      e_req = !redir && !br_stall && inf < OUTS && inf + occ < QD && !mis;
      chk("req", 32'(inst_sram_req), 32'(e_req));
      chk("addr", inst_sram_addr, model_pc);
      chk("valid", 32'(fs_to_ds_valid), 32'(occ != 0));
      if (occ == 0) begin
        chk("empty_pc", fs_pc, 0);
        chk("empty_inst", fs_inst, 0);
        chk("empty_adef", 32'(fs_adef_ex), 0);
      end
      if (fs_to_ds_valid && !seen_valid) begin
        seen_valid = 1;
        chk("first_valid_lat", 32'(last_dok), 1);
      end
      last_dok = inst_sram_data_ok;
      if (fs_to_ds_valid && ds_allowin && occ > 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", fs_pc, e.pc);
        chk("pop_inst", fs_inst, e.inst);
        chk("pop_adef", 32'(fs_adef_ex), 32'(e.adef));
        pops++;
      end
      if (inst_sram_data_ok && inf > 0) begin
        p = pend.pop_front();
        if (!p.stale && !redir) exp_q.push_back('{pc: p.addr, inst: rd_of(p.addr), adef: 1'b0});
      end
      if (mis && !adef_done && !redir && inf == 0 && occ < QD) begin
        exp_q.push_back('{pc: model_pc, inst: 32'h0, adef: 1'b1});
        adef_done = 1;
      end
      if (redir) begin
        exp_q.delete();
        foreach (pend[i]) pend[i].stale = 1;
        model_pc = wb_ex ? ex_entry : ertn_flush ? ertn_entry : br_target;
        adef_done = 0;
      end else if (inst_sram_req && inst_sram_addr_ok) begin
        pend.push_back('{addr: inst_sram_addr, stale: 0});
        req_log.push_back(inst_sram_addr);
        model_pc += 32'd4;
        hs++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic drain();
    br_stall = 1;
    ds_allowin = 1;
    resp_en = 1;
    run(8);
    br_stall = 0;
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      if (fs_to_ds_valid) break;
      cyc();
    end
    chk("wait_valid", 32'(fs_to_ds_valid), 1);
  endtask
  task automatic redirect_br(input logic [31:0] t);
    br_taken = 1;
    br_target = t;
    cyc();
    br_taken = 0;
  endtask
  initial begin
    resetn = 0;
    run(3);
    chk("rst_valid", 32'(fs_to_ds_valid), 0);
    chk("rst_addr", inst_sram_addr, RPC);
    resetn = 1;
    ds_allowin = 1;
    run(12);
    chk("seq0", req_log[0], 32'h1c000000);
    chk("seq1", req_log[1], 32'h1c000004);
    chk("seq2", req_log[2], 32'h1c000008);
    drain();
    resp_en = 0;
    hs = 0;
    run(6);
    chk("outstanding_hs", hs, 2);
    chk("outstanding_req", 32'(inst_sram_req), 0);
    resp_en = 1;
    drain();
    ds_allowin = 0;
    hs = 0;
    run(12);
    inst0 = fs_inst;
    run(4);
    chk("qfull_hs", hs, 4);
    chk("qfull_req", 32'(inst_sram_req), 0);
    chk("qfull_inst_stable", fs_inst, inst0);
    ds_allowin = 1;
    run(10);
    drain();
    resp_en = 0;
    run(3);
    chk("two_inflight", pend.size(), 2);
    redirect_br(32'h1c000100);
    resp_en = 1;
    wait_valid();
    chk("br_first_pc", fs_pc, 32'h1c000100);
    drain();
    br_stall = 1;
    wb_ex = 1;
    ex_entry = 32'h1c008000;
    br_taken = 1;
    br_target = 32'h1c000200;
    cyc();
    wb_ex = 0;
    br_taken = 0;
    br_stall = 0;
    #1;
    chk("wb_req", 32'(inst_sram_req), 1);
    chk("wb_addr", inst_sram_addr, 32'h1c008000);
    drain();
    ertn_flush = 1;
    ertn_entry = 32'h1c009000;
    br_taken = 1;
    br_target = 32'h1c000300;
    cyc();
    ertn_flush = 0;
    br_taken = 0;
    #1;
    chk("ertn_addr", inst_sram_addr, 32'h1c009000);
    drain();
    pops = 0;
    redirect_br(32'h1c000102);
    wait_valid();
    chk("adef_pc", fs_pc, 32'h1c000102);
    chk("adef_flag", 32'(fs_adef_ex), 32'(ADEF));
    if (ADEF) begin
      run(8);
      chk("adef_hold_req", 32'(inst_sram_req), 0);
      chk("adef_single", pops, 1);
    end
    redirect_br(32'h1c000000);
    run(6);
    resp_en = 0;
    resetn = 0;
    run(2);
    resetn = 1;
    br_stall = 1;
    force_dok = 1;
    run(3);
    chk("stale_dok_valid", 32'(fs_to_ds_valid), 0);
    force_dok = 0;
    br_stall = 0;
    resp_en = 1;
    run(10);
    chk("post_reset_pc", req_log[0], RPC);
    chk("post_reset_pc1", req_log[1], RPC + 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
